// File: rtl/stage_waveform_generator_multimode_if.sv
// Quarter-wave table load stream between a table source and the waveform stage.
// The master pushes words after loadStart; the slave reports per-word and whole-table readiness.
interface stage_waveform_generator_multimode_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic                    loadStart;
    logic                    loadValid;
    logic [SAMPLE_WIDTH-1:0] loadData;
    logic                    loadReady;
    logic                    tableReady;

    modport master (output loadStart, loadValid, loadData, input loadReady, tableReady);
    modport slave  (input loadStart, loadValid, loadData, output loadReady, tableReady);
endinterface

// File: rtl/stage_waveform_generator_multimode.sv
// Operator waveform stage: maps a phase word to a SINE/TRIANGLE/SAW/SQUARE sample in 3 cycles.
// The sine quarter-wave table is filled at runtime through the load stream interface.
module stage_waveform_generator_multimode #(
    parameter int PHASE_WIDTH      = 17,
    parameter int TABLE_ADDR_WIDTH = 14,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int VOP_WIDTH        = 9,
    parameter int ALGO_WIDTH       = 16
) (
    input  logic                           i_Clock,
    input  logic                           i_Reset_n,
    input  logic                           i_Valid,
    input  logic [1:0]                     i_WaveSelect,
    input  logic [PHASE_WIDTH-1:0]         i_Phase,
    input  logic [VOP_WIDTH-1:0]           i_VoiceOperator,
    input  logic [ALGO_WIDTH-1:0]          i_AlgorithmWord,
    input  logic                           i_NoteOn,
    stage_waveform_generator_multimode_if.slave loadIf,
    output logic                           o_Valid,
    output logic [VOP_WIDTH-1:0]           o_VoiceOperator,
    output logic [ALGO_WIDTH-1:0]          o_AlgorithmWord,
    output logic                           o_NoteOn,
    output logic signed [SAMPLE_WIDTH-1:0] o_Waveform
);
    localparam int P        = PHASE_WIDTH;
    localparam int A        = TABLE_ADDR_WIDTH;
    localparam int S        = SAMPLE_WIDTH;
    localparam int DEPTH    = 2 ** A;
    localparam int SAW_BITS = P - 2;

    typedef enum logic [1:0] {EMPTY, LOADING, READY} loadStateT;
    typedef enum logic [1:0] {SINE, TRIANGLE, SAW, SQUARE} waveModeT;

    loadStateT      loadState, loadStateNext;
    logic [A-1:0]   loadCount, loadCountNext;
    logic           loadWrite;

    logic [S-2:0]   waveTable [DEPTH];
    logic [S-2:0]   tableWord;

    logic [A-1:0]   foldIndex;
    logic [S-2:0]   sawLow;
    logic [S-2:0]   triMag;

    logic           s1Valid, s1NoteOn, s1Half;
    logic [VOP_WIDTH-1:0]  s1Vop;
    logic [ALGO_WIDTH-1:0] s1Algo;
    waveModeT       s1Mode;
    logic [A-1:0]   s1Index;
    logic [S-1:0]   s1Saw;

    logic           s2Valid, s2NoteOn, s2Half, s2SineOk;
    logic [VOP_WIDTH-1:0]  s2Vop;
    logic [ALGO_WIDTH-1:0] s2Algo;
    waveModeT       s2Mode;
    logic [S-2:0]   s2Mag;
    logic [S-1:0]   s2Saw;

    logic [S-2:0]   stage3Mag;
    logic [S-1:0]   magExt;
    logic [S-1:0]   stage3Wave;

    logic           unusedBits;
    assign unusedBits = ^{i_Phase[P-1], loadIf.loadData[S-1]};

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            loadState <= EMPTY;
            loadCount <= '0;
        end else begin
            loadState <= loadStateNext;
            loadCount <= loadCountNext;
        end
    end

    // A restart always wins, so a word offered in the same cycle is dropped.
    always_comb begin
        loadStateNext = loadState;
        loadCountNext = loadCount;
        loadWrite     = 1'b0;
        if (loadIf.loadStart) begin
            loadStateNext = LOADING;
            loadCountNext = '0;
        end else if (loadState == LOADING && loadIf.loadValid) begin
            loadWrite     = 1'b1;
            loadCountNext = loadCount + A'(1);
            if (&loadCount) loadStateNext = READY;
        end
    end

    assign loadIf.loadReady  = (loadState == LOADING);
    assign loadIf.tableReady = (loadState == READY);

    // Single-port table: writes only while loading, reads only otherwise.
    always_ff @(posedge i_Clock) begin
        if (loadState == LOADING) begin
            if (loadWrite) waveTable[loadCount] <= loadIf.loadData[S-2:0];
        end else begin
            tableWord <= waveTable[s1Index];
        end
    end

    assign foldIndex = i_Phase[P-3] ? ~i_Phase[P-4 -: A] : i_Phase[P-4 -: A];

    generate
        if (SAW_BITS >= S - 1) begin : gSawTrunc
            assign sawLow = i_Phase[P-3 -: S-1];
        end else begin : gSawPad
            assign sawLow = {i_Phase[P-3:0], {(S-1-SAW_BITS){1'b0}}};
        end

        if (A >= S - 1) begin : gTriTrunc
            assign triMag = s1Index[A-1 -: S-1];
        end else begin : gTriPad
            assign triMag = {s1Index, {(S-1-A){1'b0}}};
        end
    endgenerate

    always_comb begin
        stage3Mag = s2Mag;
        if (s2Mode == SINE) stage3Mag = s2SineOk ? tableWord : '0;
        magExt     = {1'b0, stage3Mag};
        stage3Wave = s2Half ? -magExt : magExt;
        if (s2Mode == SAW) stage3Wave = s2Saw;
    end

    // Sideband rides alongside the sample so every output lines up 3 cycles after its request.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            s1Valid         <= 1'b0;
            s1NoteOn        <= 1'b0;
            s1Half          <= 1'b0;
            s1Vop           <= '0;
            s1Algo          <= '0;
            s1Mode          <= SINE;
            s1Index         <= '0;
            s1Saw           <= '0;
            s2Valid         <= 1'b0;
            s2NoteOn        <= 1'b0;
            s2Half          <= 1'b0;
            s2SineOk        <= 1'b0;
            s2Vop           <= '0;
            s2Algo          <= '0;
            s2Mode          <= SINE;
            s2Mag           <= '0;
            s2Saw           <= '0;
            o_Valid         <= 1'b0;
            o_VoiceOperator <= '0;
            o_AlgorithmWord <= '0;
            o_NoteOn        <= 1'b0;
            o_Waveform      <= '0;
        end else begin
            s1Valid         <= i_Valid;
            s1NoteOn        <= i_NoteOn;
            s1Half          <= i_Phase[P-2];
            s1Vop           <= i_VoiceOperator;
            s1Algo          <= i_AlgorithmWord;
            s1Mode          <= waveModeT'(i_WaveSelect);
            s1Index         <= foldIndex;
            s1Saw           <= {~i_Phase[P-2], sawLow};
            s2Valid         <= s1Valid;
            s2NoteOn        <= s1NoteOn;
            s2Half          <= s1Half;
            s2SineOk        <= (loadState == READY);
            s2Vop           <= s1Vop;
            s2Algo          <= s1Algo;
            s2Mode          <= s1Mode;
            s2Mag           <= (s1Mode == SQUARE) ? {(S-1){1'b1}} : triMag;
            s2Saw           <= s1Saw;
            o_Valid         <= s2Valid;
            o_VoiceOperator <= s2Vop;
            o_AlgorithmWord <= s2Algo;
            o_NoteOn        <= s2NoteOn;
            o_Waveform      <= stage3Wave;
        end
    end
endmodule
